z80_ld_dd_extaddr_seq: RTL and testbench
========================================

// Module: z80_ld_dd_extaddr_seq
// PURPOSE
//  Execution sequencer for the 16-bit load LD dd,(nn) (ED 4B/5B/6B/7B): the read-side counterpart of LD (nn),dd.
//  Dispatched by the core decoder after ED + opcode byte are fetched.
//  Fetches nL/nH operand bytes, reads memory[nn] (low) and memory[nn+1] (high) little-endian.
//  Writes register pair dd and advances PC by 4. Sits between decoder, memory bus arbiter and register file.
// PARAMETERS
//  MAX_WAIT  255  max cycles a bus read may stall before abort; 0 = no timeout
// PORTS
//  clk        in   1   core clock; all state changes on rising edge
//  reset      in   1   synchronous, active-high reset
//  start      in   1   dispatch pulse from decoder; sampled only in IDLE
//  pc_in      in   16  address of the ED prefix byte
//  opcode     in   8   second instruction byte (01dd1011 expected)
//  busy       out  1   high in every state except IDLE
//  mem_rd     out  1   bus read request
//  mem_addr   out  16  bus read address; stable while mem_rd high
//  mem_rdata  in   8   bus read data; valid when mem_ready high
//  mem_ready  in   1   read completes on edge where mem_rd && mem_ready
//  reg_we     out  1   register-pair write strobe (one cycle)
//  reg_wnum   out  4   register number {2'b10, dd}
//  reg_wdata  out  16  {mem[nn+1], mem[nn]}
//  pc_we      out  1   PC write strobe (same cycle as reg_we)
//  pc_wdata   out  16  pc_in + 4, mod 2^16
//  done       out  1   retire pulse (same cycle as reg_we)
//  illegal    out  1   one-cycle pulse: opcode not 01dd1011
//  timeout    out  1   one-cycle pulse: read stalled > MAX_WAIT cycles
// BEHAVIOUR
//  States: IDLE -> FETCH_NL -> FETCH_NH -> READ_LO -> READ_HI -> WB -> IDLE.
//  Reset: state IDLE; all outputs 0; latched pc/dd/nn/data cleared.
//   Reset mid-operation abandons instruction: no reg/PC write, mem_rd low next cycle.
//  IDLE: start && opcode[7:6]==01 && opcode[3:0]==1011 -> latch pc_in, dd=opcode[5:4]; go FETCH_NL.
//   start with any other opcode -> illegal=1 next cycle, stay IDLE, no bus activity.
//   start while busy is ignored (decoder must not issue it).
//  FETCH_NL: mem_rd=1, addr=pc+2; on ready latch nL -> FETCH_NH.
//  FETCH_NH: mem_rd=1, addr=pc+3; on ready latch nH -> READ_LO.
//  READ_LO: mem_rd=1, addr=nn; on ready latch lo -> READ_HI.
//  READ_HI: mem_rd=1, addr=nn+1; on ready latch hi -> WB.
//  All address adds wrap mod 2^16 (pc=FFFE -> operands at 0000/0001; nn=FFFF -> high byte from 0000).
//  mem_rd is registered; deasserts the cycle after the completing handshake unless next state also reads,
//   in which case it stays high with the new address (back-to-back reads allowed).
//  WB: reg_we=pc_we=done=1 for exactly one cycle; writeback atomic (both bytes in one strobe). -> IDLE.
//  Latency, zero-wait bus: start in cycle 0, reads in cycles 1-4, done in cycle 5; next start accepted cycle 6.
//   Each wait cycle adds one.
//  Timeout: per-request wait counter cleared when a read is issued or completes.
//   Counter reaches MAX_WAIT with no ready -> timeout=1, mem_rd=0, IDLE, no reg/PC write.
//  dd=11 writes SP (reg_wnum 4'b1011); no flags affected; reg_wdata/pc_wdata hold last value when strobes low.
// TESTING
//  1. Reset, start op=4B pc=0100, bytes 34 12, mem[1234]=CD mem[1235]=AB, zero-wait
//     -> done cycle 5, reg_wnum=1000 wdata=ABCD, pc_wdata=0104.
//  2. Op=7B nn=FFFF, mem[FFFF]=11 mem[0000]=22 -> reads FFFF then 0000; reg_wnum=1011 wdata=2211.
//  3. pc=FFFE op=5B -> operand fetches at 0000,0001; pc_wdata=0002.
//  4. Op=4A or 8B -> illegal pulse next cycle, mem_rd never high, busy stays 0.
//  5. mem_ready held low 3 cycles on READ_LO (MAX_WAIT=255) -> mem_addr stable, done in cycle 8;
//     MAX_WAIT=2 with ready low -> timeout, no reg_we.
//  6. Assert reset during READ_HI -> next cycle all outputs 0, IDLE, no reg_we/pc_we; new start completes normally.

Source files
------------

// File: rtl/z80_ld_dd_extaddr_seq_if.sv
// Memory read bus between the LD dd,(nn) sequencer (master) and the bus arbiter (slave).
// A read completes on the rising edge where mem_rd && mem_ready.
interface z80_ld_dd_extaddr_seq_if;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        mem_ready;

  modport master (output mem_rd, output mem_addr, input mem_rdata, input mem_ready);
  modport slave  (input mem_rd, input mem_addr, output mem_rdata, output mem_ready);
endinterface

// File: rtl/z80_ld_dd_extaddr_seq.sv
// Execution sequencer for LD dd,(nn) (ED 4B/5B/6B/7B): fetches nn, reads a little-endian
// word from memory[nn], then writes register pair dd and PC+4 in one atomic strobe.
module z80_ld_dd_extaddr_seq #(
  parameter int MAX_WAIT = 255
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [15:0]                     pc_in,
  input  logic [7:0]                      opcode,
  output logic                            busy,
  z80_ld_dd_extaddr_seq_if.master         bus,
  output logic                            reg_we,
  output logic [3:0]                      reg_wnum,
  output logic [15:0]                     reg_wdata,
  output logic                            pc_we,
  output logic [15:0]                     pc_wdata,
  output logic                            done,
  output logic                            illegal,
  output logic                            timeout
);

  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH_NL = 3'd1,
    FETCH_NH = 3'd2,
    READ_LO  = 3'd3,
    READ_HI  = 3'd4,
    WB       = 3'd5
  } state_t;

  state_t        state;
  logic [15:0]   pc_q;
  logic [15:0]   nn_q;
  logic [1:0]    dd_q;
  logic [7:0]    lo_q;
  logic [CW-1:0] wait_cnt;
  logic          legal;
  logic          handshake;
  logic          stall_out;

  assign legal     = (opcode[7:6] == 2'b01) && (opcode[3:0] == 4'b1011);
  assign handshake = bus.mem_rd && bus.mem_ready;
  // The (MAX_WAIT+1)-th consecutive stalled cycle aborts the instruction.
  assign stall_out = (MAX_WAIT != 0) && bus.mem_rd && !bus.mem_ready &&
                     (wait_cnt == CW'(MAX_WAIT));
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pc_q         <= '0;
      nn_q         <= '0;
      dd_q         <= '0;
      lo_q         <= '0;
      wait_cnt     <= '0;
      bus.mem_rd   <= 1'b0;
      bus.mem_addr <= '0;
      reg_we       <= 1'b0;
      reg_wnum     <= '0;
      reg_wdata    <= '0;
      pc_we        <= 1'b0;
      pc_wdata     <= '0;
      done         <= 1'b0;
      illegal      <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      reg_we  <= 1'b0;
      pc_we   <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (legal) begin
              pc_q         <= pc_in;
              dd_q         <= opcode[5:4];
              wait_cnt     <= '0;
              bus.mem_rd   <= 1'b1;
              bus.mem_addr <= pc_in + 16'd2;
              state        <= FETCH_NL;
            end else begin
              illegal <= 1'b1;
            end
          end
        end
        FETCH_NL, FETCH_NH, READ_LO, READ_HI: begin
          if (handshake) begin
            wait_cnt <= '0;
            case (state)
              FETCH_NL: begin
                nn_q[7:0]    <= bus.mem_rdata;
                bus.mem_addr <= pc_q + 16'd3;
                state        <= FETCH_NH;
              end
              FETCH_NH: begin
                nn_q[15:8]   <= bus.mem_rdata;
                bus.mem_addr <= {bus.mem_rdata, nn_q[7:0]};
                state        <= READ_LO;
              end
              READ_LO: begin
                lo_q         <= bus.mem_rdata;
                bus.mem_addr <= nn_q + 16'd1;
                state        <= READ_HI;
              end
              default: begin
                // Both bytes land in the register file with a single strobe.
                bus.mem_rd <= 1'b0;
                reg_we     <= 1'b1;
                pc_we      <= 1'b1;
                done       <= 1'b1;
                reg_wnum   <= {2'b10, dd_q};
                reg_wdata  <= {bus.mem_rdata, lo_q};
                pc_wdata   <= pc_q + 16'd4;
                state      <= WB;
              end
            endcase
          end else if (stall_out) begin
            bus.mem_rd <= 1'b0;
            timeout    <= 1'b1;
            state      <= IDLE;
          end else if (bus.mem_rd) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        WB:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_z80_ld_dd_extaddr_seq.sv
// Directed bench for z80_ld_dd_extaddr_seq with a transaction-level reference model
// and a second instance built with MAX_WAIT=2 for the read-stall abort.
module tb_z80_ld_dd_extaddr_seq;
  localparam int MW = 255;

  logic        clk = 1'b0;
  logic        reset, start, start2, rdy, rdy2;
  logic [15:0] pc_in;
  logic [7:0]  opcode;
  logic        busy, reg_we, pc_we, done, illegal, timeout;
  logic [3:0]  reg_wnum;
  logic [15:0] reg_wdata, pc_wdata;
  logic        busy2, reg_we2, pc_we2, done2, illegal2, timeout2;
  logic [3:0]  reg_wnum2;
  logic [15:0] reg_wdata2, pc_wdata2;
  logic [7:0]  mem [0:65535];

  z80_ld_dd_extaddr_seq_if bus ();
  z80_ld_dd_extaddr_seq_if bus2 ();
  assign bus.mem_rdata  = mem[bus.mem_addr];
  assign bus.mem_ready  = rdy;
  assign bus2.mem_rdata = mem[bus2.mem_addr];
  assign bus2.mem_ready = rdy2;

  z80_ld_dd_extaddr_seq #(.MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .start(start), .pc_in(pc_in), .opcode(opcode),
    .busy(busy), .bus(bus), .reg_we(reg_we), .reg_wnum(reg_wnum), .reg_wdata(reg_wdata),
    .pc_we(pc_we), .pc_wdata(pc_wdata), .done(done), .illegal(illegal), .timeout(timeout));

  z80_ld_dd_extaddr_seq #(.MAX_WAIT(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .pc_in(pc_in), .opcode(opcode),
    .busy(busy2), .bus(bus2), .reg_we(reg_we2), .reg_wnum(reg_wnum2), .reg_wdata(reg_wdata2),
    .pc_we(pc_we2), .pc_wdata(pc_wdata2), .done(done2), .illegal(illegal2), .timeout(timeout2));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: an instruction in flight is a list of four read addresses plus
  // the expected writeback; one read retires per cycle in which ready is high.
  bit          chk_en = 0;
  bit          m_act = 0, m_ill = 0, m_to = 0;
  int          m_rd = 0, m_stall = 0;
  logic [15:0] m_addr [4];
  logic [15:0] m_data, m_pc4;
  logic [3:0]  m_wnum;
  logic [15:0] rd_log [4];
  int          rd_n = 0;
  bit          we2_seen = 0;

  always @(negedge clk) begin : cmp
    bit e_rd, e_done;
    logic [15:0] p2, p3, nn, nn1;
    e_rd   = m_act && (m_rd < 4);
    e_done = m_act && (m_rd == 4);
    if (chk_en) begin
      chk("busy", busy, m_act);
      chk("mem_rd", bus.mem_rd, e_rd);
      chk("done", done, e_done);
      chk("reg_we", reg_we, e_done);
      chk("pc_we", pc_we, e_done);
      chk("illegal", illegal, m_ill);
      chk("timeout", timeout, m_to);
      if (e_rd) chk("mem_addr", bus.mem_addr, m_addr[m_rd]);
      if (e_done) begin
        chk("reg_wnum", reg_wnum, m_wnum);
        chk("reg_wdata", reg_wdata, m_data);
        chk("pc_wdata", pc_wdata, m_pc4);
      end
    end
    if (reg_we2) we2_seen = 1;
    if (bus.mem_rd && rdy && rd_n < 4) begin
      rd_log[rd_n] = bus.mem_addr;
      rd_n++;
    end
    m_ill = 0;
    m_to  = 0;
    if (reset) begin
      m_act = 0;
      m_rd  = 0;
    end else if (!m_act) begin
      if (start) begin
        if ((opcode & 8'hCF) == 8'h4B) begin
          p2  = pc_in + 16'd2;
          p3  = pc_in + 16'd3;
          nn  = {mem[p3], mem[p2]};
          nn1 = nn + 16'd1;
          m_addr[0] = p2;
          m_addr[1] = p3;
          m_addr[2] = nn;
          m_addr[3] = nn1;
          m_data  = {mem[nn1], mem[nn]};
          m_pc4   = pc_in + 16'd4;
          m_wnum  = {2'b10, opcode[5:4]};
          m_act   = 1;
          m_rd    = 0;
          m_stall = 0;
        end else begin
          m_ill = 1;
        end
      end
    end else if (m_rd < 4) begin
      if (rdy) begin
        m_rd++;
        m_stall = 0;
      end else begin
        m_stall++;
        if (MW != 0 && m_stall > MW) begin
          m_to  = 1;
          m_act = 0;
        end
      end
    end else begin
      m_act = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int t0, output int lat);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        lat = cyc - t0;
        break;
      end
      tick();
    end
  endtask

  task automatic run_op(input logic [15:0] pc, input logic [7:0] op, output int lat);
    int t0;
    tick();
    pc_in = pc; opcode = op; start = 1'b1; t0 = cyc; rd_n = 0;
    tick();
    start = 1'b0;
    wait_done(t0, lat);
  endtask

  task automatic try_illegal(input logic [7:0] op);
    tick();
    pc_in = 16'h0400; opcode = op; start = 1'b1;
    tick();
    start = 1'b0;
    chk("illegal_pulse", illegal, 1'b1);
    chk("illegal_busy", busy, 1'b0);
    chk("illegal_mem_rd", bus.mem_rd, 1'b0);
    tick();
    chk("illegal_clear", illegal, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, t0;
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    reset = 1'b1; start = 1'b0; start2 = 1'b0; rdy = 1'b1; rdy2 = 1'b0;
    pc_in = '0; opcode = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_rd", bus.mem_rd, 1'b0);
    chk("rst_reg_we", reg_we, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_reg_wdata", reg_wdata, 16'h0000);
    chk("rst_pc_wdata", pc_wdata, 16'h0000);
    chk_en = 1;

    // LD BC,(1234h) at 0100h, zero-wait
    mem[16'h0102] = 8'h34; mem[16'h0103] = 8'h12;
    mem[16'h1234] = 8'hCD; mem[16'h1235] = 8'hAB;
    run_op(16'h0100, 8'h4B, lat);
    chk("t1_latency", lat, 5);
    chk("t1_wnum", reg_wnum, 4'b1000);
    chk("t1_wdata", reg_wdata, 16'hABCD);
    chk("t1_pc", pc_wdata, 16'h0104);

    // LD SP,(FFFFh): high byte wraps to 0000h; issued the cycle after done
    mem[16'h0202] = 8'hFF; mem[16'h0203] = 8'hFF;
    mem[16'hFFFF] = 8'h11; mem[16'h0000] = 8'h22;
    run_op(16'h0200, 8'h7B, lat);
    chk("t2_latency", lat, 5);
    chk("t2_rd_lo", rd_log[2], 16'hFFFF);
    chk("t2_rd_hi", rd_log[3], 16'h0000);
    chk("t2_wnum", reg_wnum, 4'b1011);
    chk("t2_wdata", reg_wdata, 16'h2211);

    // LD DE,(5678h) at FFFEh: operand fetches wrap
    mem[16'h0000] = 8'h78; mem[16'h0001] = 8'h56;
    mem[16'h5678] = 8'hEF; mem[16'h5679] = 8'hBE;
    run_op(16'hFFFE, 8'h5B, lat);
    chk("t3_rd_nl", rd_log[0], 16'h0000);
    chk("t3_rd_nh", rd_log[1], 16'h0001);
    chk("t3_pc", pc_wdata, 16'h0002);
    chk("t3_wnum", reg_wnum, 4'b1001);
    chk("t3_wdata", reg_wdata, 16'hBEEF);

    try_illegal(8'h4A);
    try_illegal(8'h8B);

    // LD HL,(4080h) with three wait cycles on the low data read
    mem[16'h0302] = 8'h80; mem[16'h0303] = 8'h40;
    mem[16'h4080] = 8'h5A; mem[16'h4081] = 8'hA5;
    tick();
    pc_in = 16'h0300; opcode = 8'h6B; start = 1'b1; t0 = cyc; rd_n = 0;
    tick(); start = 1'b0;
    tick();
    tick(); rdy = 1'b0;
    chk("t5_addr_w0", bus.mem_addr, 16'h4080);
    tick();
    chk("t5_addr_w1", bus.mem_addr, 16'h4080);
    tick();
    chk("t5_addr_w2", bus.mem_addr, 16'h4080);
    tick(); rdy = 1'b1;
    chk("t5_addr_go", bus.mem_addr, 16'h4080);
    chk("t5_rd_go", bus.mem_rd, 1'b1);
    wait_done(t0, lat);
    chk("t5_latency", lat, 8);
    chk("t5_wnum", reg_wnum, 4'b1010);
    chk("t5_wdata", reg_wdata, 16'hA55A);

    // MAX_WAIT=2 instance, ready never returns
    tick();
    pc_in = 16'h0100; opcode = 8'h4B; start2 = 1'b1; t0 = cyc;
    tick(); start2 = 1'b0;
    chk("to_rd_c1", bus2.mem_rd, 1'b1);
    tick();
    tick();
    chk("to_rd_c3", bus2.mem_rd, 1'b1);
    chk("to_pulse_c3", timeout2, 1'b0);
    tick();
    chk("to_pulse_c4", timeout2, 1'b1);
    chk("to_rd_c4", bus2.mem_rd, 1'b0);
    chk("to_busy_c4", busy2, 1'b0);
    tick();
    chk("to_pulse_c5", timeout2, 1'b0);

    // Reset during READ_HI abandons the instruction
    tick();
    pc_in = 16'h0100; opcode = 8'h4B; start = 1'b1; rd_n = 0;
    tick(); start = 1'b0;
    tick();
    tick();
    tick();
    chk("t6_in_read_hi", bus.mem_addr, 16'h1235);
    reset = 1'b1;
    tick(); reset = 1'b0;
    chk("t6_busy", busy, 1'b0);
    chk("t6_mem_rd", bus.mem_rd, 1'b0);
    chk("t6_reg_we", reg_we, 1'b0);
    chk("t6_pc_we", pc_we, 1'b0);
    chk("t6_done", done, 1'b0);
    chk("t6_reg_wdata", reg_wdata, 16'h0000);
    chk("t6_pc_wdata", pc_wdata, 16'h0000);
    run_op(16'h0100, 8'h4B, lat);
    chk("t6_restart_latency", lat, 5);
    chk("t6_restart_wdata", reg_wdata, 16'hABCD);

    tick();
    tick();
    chk("we2_never", we2_seen, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
